// File: rtl/gpio_pkg.sv
// Shared register map, BSR field positions and APB handshake states for the APB GPIO block.
package gpio_pkg;

   localparam int MAX_PINS = 16;

   localparam logic [4:0] GPIO_CR   = 5'h00;
   localparam logic [4:0] GPIO_IDR  = 5'h04;
   localparam logic [4:0] GPIO_ODR  = 5'h08;
   localparam logic [4:0] GPIO_BSR  = 5'h0C;
   localparam logic [4:0] GPIO_RIE  = 5'h10;
   localparam logic [4:0] GPIO_FIE  = 5'h14;
   localparam logic [4:0] GPIO_ISR  = 5'h18;
   localparam logic [4:0] GPIO_RSVD = 5'h1C;

   localparam int BSR_SET_LSB = 0;
   localparam int BSR_CLR_LSB = 16;

   typedef enum logic {
      APB_IDLE = 1'b0,
      APB_ACK  = 1'b1
   } apb_state_e;

   // Pin-wide register values always land in the low bits of the 32-bit bus.
   function automatic logic [31:0] zext_pins(input logic [MAX_PINS-1:0] v);
      return {{(32-MAX_PINS){1'b0}}, v};
   endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Pad input synchroniser with one edge-history flop per pin; rise/fall compare the
// last synchroniser stage against its value one cycle earlier.
module gpio_in_sync
   import gpio_pkg::*;
#(
   parameter int N           = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [N-1:0] pad_i,
   output logic [N-1:0] sync,
   output logic [N-1:0] rise,
   output logic [N-1:0] fall
);

   logic [SYNC_STAGES-1:0][N-1:0] stage_q;
   logic [N-1:0]                  prev_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stage_q <= '0;
         prev_q  <= '0;
      end else begin
         stage_q <= {stage_q[SYNC_STAGES-2:0], pad_i};
         prev_q  <= stage_q[SYNC_STAGES-1];
      end
   end

   assign sync = stage_q[SYNC_STAGES-1];
   assign rise = sync & ~prev_q;
   assign fall = ~sync & prev_q;

endmodule

// File: rtl/gpio_apb_irq.sv
// APB GPIO peripheral: direction/output/edge-enable/pending registers, atomic BSR,
// one-wait-state APB slave and a flop-driven level interrupt.
module gpio_apb_irq
   import gpio_pkg::*;
#(
   parameter int N           = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic         PCLK,
   input  logic         PRESET,
   input  logic [4:0]   PADDR,
   input  logic         PWRITE,
   input  logic         PENABLE,
   input  logic [31:0]  PWDATA,
   input  logic         PSEL,
   output logic [31:0]  PRDATA,
   output logic         PREADY,
   output logic         irq,
   inout  wire [N-1:0]  gpio
);

   apb_state_e          state_q, state_d;
   logic                acc;
   logic [4:0]          reg_off;
   logic [N-1:0]        wdata;
   logic [N-1:0]        cr_q, cr_d, odr_q, odr_d;
   logic [N-1:0]        rie_q, rie_d, fie_q, fie_d, isr_q, isr_d;
   logic [31:0]         prdata_q, prdata_d;
   logic                irq_q;
   logic [MAX_PINS-1:0] rd_pins;
   logic [N-1:0]        pad_sync, pad_rise, pad_fall;
   logic                unused_ok;

   assign reg_off   = {PADDR[4:2], 2'b00};
   assign wdata     = PWDATA[N-1:0];
   assign unused_ok = ^{PADDR[1:0], PWDATA};

   gpio_in_sync #(
      .N           (N),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_in_sync (
      .clk_i (PCLK),
      .rst_i (PRESET),
      .pad_i (gpio),
      .sync  (pad_sync),
      .rise  (pad_rise),
      .fall  (pad_fall)
   );

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q  <= APB_IDLE;
         cr_q     <= '0;
         odr_q    <= '0;
         rie_q    <= '0;
         fie_q    <= '0;
         isr_q    <= '0;
         prdata_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cr_q     <= cr_d;
         odr_q    <= odr_d;
         rie_q    <= rie_d;
         fie_q    <= fie_d;
         isr_q    <= isr_d;
         prdata_q <= prdata_d;
         irq_q    <= |isr_d;
      end
   end

   // The access commits on the entry edge into ACK; ACK always falls back to IDLE so
   // a master still holding PSEL/PENABLE cannot trigger a second access.
   always_comb begin
      state_d = state_q;
      acc     = 1'b0;
      case (state_q)
         APB_IDLE: begin
            if (PSEL && PENABLE) begin
               state_d = APB_ACK;
               acc     = 1'b1;
            end
         end
         APB_ACK:  state_d = APB_IDLE;
         default:  state_d = APB_IDLE;
      endcase
   end

   always_comb begin
      cr_d     = cr_q;
      odr_d    = odr_q;
      rie_d    = rie_q;
      fie_d    = fie_q;
      isr_d    = isr_q;
      prdata_d = prdata_q;
      rd_pins  = '0;

      case (reg_off)
         GPIO_CR:  rd_pins[N-1:0] = cr_q;
         GPIO_IDR: rd_pins[N-1:0] = pad_sync;
         GPIO_ODR: rd_pins[N-1:0] = odr_q;
         GPIO_RIE: rd_pins[N-1:0] = rie_q;
         GPIO_FIE: rd_pins[N-1:0] = fie_q;
         GPIO_ISR: rd_pins[N-1:0] = isr_q;
         default:  rd_pins        = '0;
      endcase

      if (acc && PWRITE) begin
         case (reg_off)
            GPIO_CR:  cr_d  = wdata;
            GPIO_ODR: odr_d = wdata;
            GPIO_BSR: odr_d = (odr_q & ~PWDATA[BSR_CLR_LSB +: N]) | PWDATA[BSR_SET_LSB +: N];
            GPIO_RIE: rie_d = wdata;
            GPIO_FIE: fie_d = wdata;
            GPIO_ISR: isr_d = isr_q & ~wdata;
            default:  ;
         endcase
      end

      if (acc && !PWRITE) begin
         prdata_d = zext_pins(rd_pins);
      end

      // Edge events are OR-ed in after the W1C so a same-cycle event keeps its bit set.
      isr_d = isr_d | (pad_rise & rie_q) | (pad_fall & fie_q);
   end

   for (genvar g = 0; g < N; g++) begin : g_pad
      assign gpio[g] = cr_q[g] ? odr_q[g] : 1'bz;
   end

   assign PREADY = (state_q == APB_ACK);
   assign PRDATA = prdata_q;
   assign irq    = irq_q;

endmodule

// File: tb/tb_gpio_apb_irq.sv
// Scoreboard bench for gpio_apb_irq: expectations are queued as stimulus is driven and
// popped against PRDATA, pad and irq observations.
`timescale 1ns/1ps
module tb_gpio_apb_irq;
   import gpio_pkg::*;

   localparam int N = 8;

   logic          PCLK = 1'b0;
   logic          PRESET;
   logic [4:0]    PADDR;
   logic          PWRITE;
   logic          PENABLE;
   logic [31:0]   PWDATA;
   logic          PSEL;
   logic [31:0]   PRDATA;
   logic          PREADY;
   logic          irq;
   wire  [N-1:0]  gpio;

   logic [N-1:0]  ext_d;
   logic [N-1:0]  ext_en;

   for (genvar g = 0; g < N; g++) begin : g_ext
      assign gpio[g] = ext_en[g] ? ext_d[g] : 1'bz;
   end

   gpio_apb_irq #(.N(N), .SYNC_STAGES(2)) dut (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .PADDR   (PADDR),
      .PWRITE  (PWRITE),
      .PENABLE (PENABLE),
      .PWDATA  (PWDATA),
      .PSEL    (PSEL),
      .PRDATA  (PRDATA),
      .PREADY  (PREADY),
      .irq     (irq),
      .gpio    (gpio)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   exp_t         exp_q[$];
   int           n_vec = 0;
   int           n_err = 0;
   int           last_hi;
   logic [N-1:0] last_pads;

   // Setup phase, access phase, wait for PREADY (bounded), then hold PSEL/PENABLE
   // across one more edge to see PREADY fall on its own.
   task automatic apb_xfer(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                           output logic [31:0] rd);
      bit seen;
      seen = 1'b0;
      @(negedge PCLK);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
      @(negedge PCLK);
      PENABLE = 1'b1;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(posedge PCLK); #1;
         seen = PREADY;
      end
      rd        = PRDATA;
      last_pads = gpio;
      last_hi   = 0;
      if (!seen) begin
         n_err++;
         $display("FAIL apb_timeout: addr %h got no PREADY, want PREADY within 8 cycles", a);
      end else begin
         last_hi = 1;
         @(posedge PCLK); #1;
         if (PREADY) last_hi = 2;
      end
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      exp_t        e;
      ext_en = '1; ext_d = 8'hA5;
      PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
      repeat (3) @(posedge PCLK);
      #1;
      exp_q.push_back('{name: "rst_pready", val: 32'h0});
      e = exp_q.pop_front(); n_vec++;
      if ({31'h0, PREADY} !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, PREADY, e.val); end
      exp_q.push_back('{name: "rst_prdata", val: 32'h0});
      e = exp_q.pop_front(); n_vec++;
      if (PRDATA !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, PRDATA, e.val); end
      @(negedge PCLK);
      PRESET = 1'b0;
      repeat (6) @(posedge PCLK);
      #1;
      exp_q.push_back('{name: "rst_release_irq", val: 32'h0});
      e = exp_q.pop_front(); n_vec++;
      if ({31'h0, irq} !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, irq, e.val); end
      exp_q.push_back('{name: "rst_pads_float", val: 32'hA5});
      e = exp_q.pop_front(); n_vec++;
      if ({24'h0, gpio} !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, gpio, e.val); end
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back('{name: $sformatf("rst_rd_off%02h", k * 4), val: (k == 1) ? 32'hA5 : 32'h0});
         apb_xfer(1'b0, 5'(k * 4), 32'h0, rd);
         e = exp_q.pop_front(); n_vec++;
         if (rd !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd, e.val); end
         n_vec++;
         if (last_hi !== 1) begin n_err++; $display("FAIL rst_pready_width_off%02h: got %0d cycles want 1", k * 4, last_hi); end
      end
   endtask

   task automatic test_output();
      logic [31:0] rd;
      exp_t        e;
      ext_en = '0;
      apb_xfer(1'b1, GPIO_CR, 32'hFFFF_FFFF, rd);
      exp_q.push_back('{name: "pads_odr_a5", val: 32'hA5});
      apb_xfer(1'b1, GPIO_ODR, 32'h0000_00A5, rd);
      e = exp_q.pop_front(); n_vec++;
      if ({24'h0, last_pads} !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, last_pads, e.val); end
      exp_q.push_back('{name: "pads_bsr_clr0_set1", val: 32'hA6});
      apb_xfer(1'b1, GPIO_BSR, 32'h0001_0002, rd);
      e = exp_q.pop_front(); n_vec++;
      if ({24'h0, last_pads} !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, last_pads, e.val); end
      exp_q.push_back('{name: "pads_bsr_set_wins", val: 32'hA7});
      apb_xfer(1'b1, GPIO_BSR, 32'h0001_0001, rd);
      e = exp_q.pop_front(); n_vec++;
      if ({24'h0, last_pads} !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, last_pads, e.val); end
      exp_q.push_back('{name: "rd_cr_masked", val: 32'hFF});
      apb_xfer(1'b0, GPIO_CR, 32'h0, rd);
      e = exp_q.pop_front(); n_vec++;
      if (rd !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd, e.val); end
      exp_q.push_back('{name: "rd_odr", val: 32'hA7});
      apb_xfer(1'b0, GPIO_ODR, 32'h0, rd);
      e = exp_q.pop_front(); n_vec++;
      if (rd !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd, e.val); end
      exp_q.push_back('{name: "rd_bsr_zero", val: 32'h0});
      apb_xfer(1'b0, GPIO_BSR, 32'h0, rd);
      e = exp_q.pop_front(); n_vec++;
      if (rd !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd, e.val); end
   endtask

   task automatic test_input();
      logic [31:0] rd;
      exp_t        e;
      apb_xfer(1'b1, GPIO_CR, 32'h0, rd);
      ext_en = '1; ext_d = 8'h00;
      repeat (4) @(posedge PCLK);
      // Pad changes one edge before PRDATA loads: the synchroniser must still show the old value.
      exp_q.push_back('{name: "idr_one_edge_old", val: 32'h00});
      fork
         apb_xfer(1'b0, GPIO_IDR, 32'h0, rd);
         begin
            @(negedge PCLK);
            @(negedge PCLK);
            ext_d = 8'h3C;
         end
      join
      e = exp_q.pop_front(); n_vec++;
      if (rd !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd, e.val); end
      exp_q.push_back('{name: "idr_3c", val: 32'h3C});
      apb_xfer(1'b0, GPIO_IDR, 32'h0, rd);
      e = exp_q.pop_front(); n_vec++;
      if (rd !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd, e.val); end
      apb_xfer(1'b1, GPIO_ODR, 32'h05, rd);
      ext_en = 8'hF0; ext_d = 8'hA0;
      apb_xfer(1'b1, GPIO_CR, 32'h0F, rd);
      repeat (3) @(posedge PCLK);
      exp_q.push_back('{name: "idr_mixed_a5", val: 32'hA5});
      apb_xfer(1'b0, GPIO_IDR, 32'h0, rd);
      e = exp_q.pop_front(); n_vec++;
      if (rd !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd, e.val); end
   endtask

   task automatic test_edge_irq();
      logic [31:0] rd;
      exp_t        e;
      apb_xfer(1'b1, GPIO_CR, 32'h0, rd);
      ext_en = '1; ext_d = 8'h80;
      repeat (4) @(posedge PCLK);
      apb_xfer(1'b1, GPIO_RIE, 32'h01, rd);
      apb_xfer(1'b1, GPIO_FIE, 32'h80, rd);
      @(negedge PCLK);
      ext_d = 8'h01;
      exp_q.push_back('{name: "irq_after_2_edges", val: 32'h0});
      exp_q.push_back('{name: "irq_after_3_edges", val: 32'h1});
      repeat (2) @(posedge PCLK);
      #1;
      e = exp_q.pop_front(); n_vec++;
      if ({31'h0, irq} !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, irq, e.val); end
      @(posedge PCLK); #1;
      e = exp_q.pop_front(); n_vec++;
      if ({31'h0, irq} !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, irq, e.val); end
      exp_q.push_back('{name: "isr_rise0_fall7", val: 32'h81});
      apb_xfer(1'b0, GPIO_ISR, 32'h0, rd);
      e = exp_q.pop_front(); n_vec++;
      if (rd !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd, e.val); end
      // Clear bit 0, then pad0 falls and pad7 rises: neither edge is enabled.
      apb_xfer(1'b1, GPIO_ISR, 32'h01, rd);
      ext_d = 8'h80;
      repeat (5) @(posedge PCLK);
      exp_q.push_back('{name: "isr_unenabled_edges", val: 32'h80});
      apb_xfer(1'b0, GPIO_ISR, 32'h0, rd);
      e = exp_q.pop_front(); n_vec++;
      if (rd !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd, e.val); end
   endtask

   task automatic test_w1c_collision();
      logic [31:0] rd;
      exp_t        e;
      // Re-arm ISR[0] so the colliding W1C has something to clear.
      ext_d = 8'h81;
      repeat (5) @(posedge PCLK);
      ext_d = 8'h80;
      repeat (5) @(posedge PCLK);
      // Pad0 rises three edges before the W1C commit edge, so both hit the same edge.
      @(negedge PCLK);
      ext_d = 8'h81;
      apb_xfer(1'b1, GPIO_ISR, 32'h01, rd);
      exp_q.push_back('{name: "isr_set_beats_w1c", val: 32'h81});
      apb_xfer(1'b0, GPIO_ISR, 32'h0, rd);
      e = exp_q.pop_front(); n_vec++;
      if (rd !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd, e.val); end
      apb_xfer(1'b1, GPIO_RIE, 32'h0, rd);
      apb_xfer(1'b1, GPIO_FIE, 32'h0, rd);
      exp_q.push_back('{name: "isr_kept_after_ie_clear", val: 32'h81});
      apb_xfer(1'b0, GPIO_ISR, 32'h0, rd);
      e = exp_q.pop_front(); n_vec++;
      if (rd !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd, e.val); end
      apb_xfer(1'b1, GPIO_ISR, 32'h81, rd);
      exp_q.push_back('{name: "irq_after_w1c", val: 32'h0});
      e = exp_q.pop_front(); n_vec++;
      if ({31'h0, irq} !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, irq, e.val); end
      exp_q.push_back('{name: "isr_after_w1c", val: 32'h0});
      apb_xfer(1'b0, GPIO_ISR, 32'h0, rd);
      e = exp_q.pop_front(); n_vec++;
      if (rd !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd, e.val); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      exp_t        e;
      ext_en = '0;
      apb_xfer(1'b1, GPIO_CR, 32'hFF, rd);
      @(negedge PCLK);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = GPIO_ODR; PWDATA = 32'h3C;
      @(negedge PCLK);
      PENABLE = 1'b1;
      #1;
      PRESET = 1'b1;
      ext_en = '1; ext_d = 8'h5A;
      #2;
      exp_q.push_back('{name: "midrst_pready", val: 32'h0});
      e = exp_q.pop_front(); n_vec++;
      if ({31'h0, PREADY} !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, PREADY, e.val); end
      exp_q.push_back('{name: "midrst_pads_float", val: 32'h5A});
      e = exp_q.pop_front(); n_vec++;
      if ({24'h0, gpio} !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, gpio, e.val); end
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0;
      @(negedge PCLK);
      PRESET = 1'b0;
      repeat (2) @(posedge PCLK);
      exp_q.push_back('{name: "midrst_odr", val: 32'h0});
      apb_xfer(1'b0, GPIO_ODR, 32'h0, rd);
      e = exp_q.pop_front(); n_vec++;
      if (rd !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd, e.val); end
      exp_q.push_back('{name: "midrst_cr", val: 32'h0});
      apb_xfer(1'b0, GPIO_CR, 32'h0, rd);
      e = exp_q.pop_front(); n_vec++;
      if (rd !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd, e.val); end
      apb_xfer(1'b1, GPIO_ODR, 32'h11, rd);
      n_vec++;
      if (last_hi !== 1) begin n_err++; $display("FAIL midrst_next_pready_width: got %0d cycles want 1", last_hi); end
      exp_q.push_back('{name: "midrst_next_odr", val: 32'h11});
      apb_xfer(1'b0, GPIO_ODR, 32'h0, rd);
      e = exp_q.pop_front(); n_vec++;
      if (rd !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd, e.val); end
   endtask

   initial begin
      ext_en = '0; ext_d = '0;
      test_reset();
      test_output();
      test_input();
      test_edge_irq();
      test_w1c_collision();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000 ns, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
